// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception responder: owns Status/Cause/EPC, issues a one-cycle PC redirect on
// trap or eret, then ignores trap/eret/mtc0 while wrong-path work drains. Option: CP0_TIMER_EN.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] STATUS_RST   = 32'h0000_0701
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    input  logic        mfc0src,
    input  logic        mtc0src,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_in,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] epc,
    output logic        redirect,
    output logic [31:0] exc_addr,
    output logic        fsm_state
);
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_status, r_epc, r_rdata, r_exc_addr;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_sw;
    logic        r_redirect;

    logic        w_en, w_accept, w_irq, w_ip7;
    logic        w_take_trap, w_take_eret, w_do_mtc0;
    logic [4:0]  w_trap_code;
    logic [31:0] w_cause, w_rd_val;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count, r_compare;
    logic        r_ip7;
    assign w_ip7 = r_ip7;
`else
    assign w_ip7 = 1'b0;
`endif

    assign w_cause = {16'b0, w_ip7, 5'b0, r_sw, 1'b0, r_exc_code, 2'b0};

    always_comb begin
        w_rd_val = 32'b0;
        case (rd_addr)
            5'd12:   w_rd_val = r_status;
            5'd13:   w_rd_val = w_cause;
            5'd14:   w_rd_val = r_epc;
`ifdef CP0_TIMER_EN
            5'd9:    w_rd_val = r_count;
            5'd11:   w_rd_val = r_compare;
`endif
            default: w_rd_val = 32'b0;
        endcase
    end

    // Next-state logic; the priority chain is trap > timer interrupt > eret > mtc0.
    always_comb begin
        w_en        = 1'b1;
        w_take_trap = 1'b0;
        w_take_eret = 1'b0;
        w_do_mtc0   = 1'b0;
        w_trap_code = cause;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (cause)
            5'b01000: w_en = r_status[8];
            5'b01001: w_en = r_status[9];
            5'b01101: w_en = r_status[10];
            default:  w_en = 1'b1;
        endcase
        w_accept = exception & r_status[0] & w_en;
        w_irq    = w_ip7 & r_status[15] & r_status[0];
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_take_trap = 1'b1;
                end else if (w_irq) begin
                    w_take_trap = 1'b1;
                    w_trap_code = 5'b0;
                end else if (eret) begin
                    w_take_eret = 1'b1;
                end else if (mtc0src) begin
                    w_do_mtc0 = 1'b1;
                end
                if (w_take_trap || w_take_eret) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (r_cnt == 4'd0) w_state_nxt = IDLE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status   <= STATUS_RST;
            r_epc      <= 32'b0;
            r_exc_code <= 5'b0;
            r_sw       <= 2'b0;
            r_rdata    <= 32'b0;
            r_redirect <= 1'b0;
            r_exc_addr <= 32'b0;
        end else begin
            r_redirect <= 1'b0;
            if (mfc0src) r_rdata <= w_rd_val;
            if (w_take_trap) begin
                r_epc      <= pc_in;
                r_exc_code <= w_trap_code;
                r_status   <= {r_status[26:0], 5'b0};
                r_redirect <= 1'b1;
                r_exc_addr <= EXC_VECTOR;
            end else if (w_take_eret) begin
                r_status   <= {5'b0, r_status[31:5]};
                r_redirect <= 1'b1;
                r_exc_addr <= r_epc;
            end else if (w_do_mtc0) begin
                case (rd_addr)
                    5'd12:   r_status <= wdata;
                    5'd13:   r_sw     <= wdata[9:8];
                    5'd14:   r_epc    <= wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    // A Compare write clears a pending match in the same edge it lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 32'b0;
            r_compare <= 32'b0;
            r_ip7     <= 1'b0;
        end else begin
            if (w_do_mtc0 && rd_addr == 5'd9) r_count <= wdata;
            else                              r_count <= r_count + 32'd1;
            if (w_do_mtc0 && rd_addr == 5'd11) begin
                r_compare <= wdata;
                r_ip7     <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'b0) begin
                r_ip7 <= 1'b1;
            end
        end
    end
`endif

    assign rdata     = r_rdata;
    assign status    = r_status;
    assign epc       = r_epc;
    assign redirect  = r_redirect;
    assign exc_addr  = r_exc_addr;
    assign fsm_state = r_state;
endmodule
